// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//
// Multi-cycle instruction sequencer for the rv32 core. Steps each instruction
// through FETCH -> DECODE -> EXEC -> WB, fetching over a valid/ready
// instruction-memory port. Each retired instruction produces exactly one
// register-file write strobe and one PC advance. The sequencer halts on
// ebreak, on an unsupported opcode, or when a fetch goes unanswered for
// TIMEOUT cycles. Only rst leaves the halted state.
//
// Parameters:
//   RESET_VECTOR  PC value loaded by reset
//   PC_INCREMENT  PC advance per retired instruction
//   TIMEOUT       max FETCH cycles without imem_rvalid (2..255)
//
// Ports:
//   clk          clock, all state changes on posedge
//   rst          synchronous active-high reset
//   imem_req     fetch request (FETCH state, not in reset)
//   imem_addr    fetch address, always equal to pc
//   imem_rvalid  instruction data valid, sampled only in FETCH
//   imem_rdata   instruction word
//   inst         latched instruction register
//   pc           current program counter
//   rf_wen       register-file write enable, WB only, rd != x0
//   halted       sticky halt flag
//   halt_code    0 running, 1 ebreak, 2 illegal opcode, 3 fetch timeout
//   retired      retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module cpu_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
  parameter logic [31:0] PC_INCREMENT = 32'd4,
  parameter int          TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        rf_wen,
  output logic        halted,
  output logic [1:0]  halt_code,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [31:0] EBREAK_WORD  = 32'h0010_0073;
  localparam logic [6:0]  OP_IMM       = 7'b0010011;
  localparam logic [6:0]  OP_REG       = 7'b0110011;
  localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);

  localparam logic [1:0] CODE_RUN     = 2'd0;
  localparam logic [1:0] CODE_EBREAK  = 2'd1;
  localparam logic [1:0] CODE_ILLEGAL = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;

  state_t     state;
  logic [7:0] wait_cnt;

  // NOTE: all state uses non-blocking assignments inside one clocked block so
  // every register samples pre-edge values; reset is synchronous, so it sits
  // inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_VECTOR;
      inst      <= '0;
      retired   <= '0;
      halted    <= 1'b0;
      halt_code <= CODE_RUN;
      wait_cnt  <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_rvalid) begin
            inst     <= imem_rdata;
            wait_cnt <= '0;
            state    <= S_DECODE;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            // TIMEOUT-th consecutive cycle without data: give up.
            halted    <= 1'b1;
            halt_code <= CODE_TIMEOUT;
            state     <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          if (inst == EBREAK_WORD) begin
            halted    <= 1'b1;
            halt_code <= CODE_EBREAK;
            state     <= S_HALT;
          end else if (inst[6:0] != OP_IMM && inst[6:0] != OP_REG) begin
            halted    <= 1'b1;
            halt_code <= CODE_ILLEGAL;
            state     <= S_HALT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: state <= S_WB;
        S_WB: begin
          pc      <= pc + PC_INCREMENT;
          retired <= retired + 32'd1;
          state   <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

  // NOTE: these strobes decode the registered state but are also gated by rst
  // directly, so they drop in the reset cycle itself rather than one cycle
  // later; a registered copy could not do that.
  assign imem_req  = (state == S_FETCH) && !rst;
  assign imem_addr = pc;
  assign rf_wen    = (state == S_WB) && (inst[11:7] != 5'd0) && !rst;

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Self-checking bench for cpu_sequencer. Each test task drives its own
// stimulus and compares inline. Retire expectations (next pc, retired count,
// write strobe, instruction period) go into a queue when an instruction is
// handed to the DUT, and come out when the DUT advances its pc.
// Outputs are sampled on the falling edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

  localparam logic [31:0] RV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        rf_wen;
  logic        halted;
  logic [1:0]  halt_code;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] retired;
    logic        wen;
    int          period;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pc_m;
  logic [31:0] ret_m;

  cpu_sequencer #(
    .RESET_VECTOR(RV),
    .PC_INCREMENT(32'd4),
    .TIMEOUT     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .pc         (pc),
    .rf_wen     (rf_wen),
    .halted     (halted),
    .halt_code  (halt_code),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst         = 1'b1;
    imem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    pc_m  = RV;
    ret_m = 32'd0;
  endtask

  // Serves one instruction after `delay` wait cycles and follows it to retire.
  // Must be entered just after a falling edge with the DUT in FETCH.
  task automatic fetch_retire(input string name, input logic [31:0] word,
                              input int delay);
    exp_t        e;
    int          cyc;
    int          wen_cnt;
    int          wen_cyc;
    logic [31:0] pc0;
    e.pc      = pc_m + 32'd4;
    e.retired = ret_m + 32'd1;
    e.wen     = (word[11:7] != 5'd0);
    e.period  = delay + 4;
    exp_q.push_back(e);
    pc0 = pc_m;
    cyc = 0;
    wen_cnt = 0;
    wen_cyc = -1;
    for (int i = 0; i <= delay; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== pc0) begin
        errors++;
        $display("FAIL %s fetch_hold cyc%0d: req=%b addr=%h, expected req=1 addr=%h",
                 name, i, imem_req, imem_addr, pc0);
      end
      imem_rvalid = (i == delay);
      imem_rdata  = (i == delay) ? word : 32'hDEAD_BEEF;
      @(negedge clk);
      cyc++;
    end
    imem_rvalid = 1'b0;
    checks++;
    if (inst !== word) begin
      errors++;
      $display("FAIL %s inst_latch: got %h, expected %h", name, inst, word);
    end
    while (pc === pc0 && cyc < delay + 12) begin
      if (rf_wen === 1'b1) begin
        wen_cnt++;
        wen_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    e = exp_q.pop_front();
    checks++;
    if (pc !== e.pc) begin
      errors++;
      $display("FAIL %s pc: got %h, expected %h", name, pc, e.pc);
    end
    checks++;
    if (retired !== e.retired) begin
      errors++;
      $display("FAIL %s retired: got %h, expected %h", name, retired, e.retired);
    end
    checks++;
    if (cyc != e.period) begin
      errors++;
      $display("FAIL %s period: got %0d cycles, expected %0d", name, cyc, e.period);
    end
    checks++;
    if (wen_cnt != int'(e.wen) || wen_cyc != (e.wen ? e.period - 1 : -1)) begin
      errors++;
      $display("FAIL %s rf_wen: got %0d pulses at cyc %0d, expected %0d at cyc %0d",
               name, wen_cnt, wen_cyc, e.wen, e.wen ? e.period - 1 : -1);
    end
    checks++;
    if (imem_req !== 1'b1 || rf_wen !== 1'b0) begin
      errors++;
      $display("FAIL %s next_fetch: req=%b wen=%b, expected req=1 wen=0",
               name, imem_req, rf_wen);
    end
    pc_m  = e.pc;
    ret_m = e.retired;
  endtask

  task automatic test_reset();
    // Reset held while memory claims valid data: inst must still clear.
    rst         = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    repeat (2) @(negedge clk);
    checks++;
    if (pc !== RV || inst !== 32'd0 || retired !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs: pc=%h inst=%h retired=%h, expected %h 0 0",
               pc, inst, retired, RV);
    end
    checks++;
    if (halted !== 1'b0 || halt_code !== 2'd0) begin
      errors++;
      $display("FAIL reset_halt: halted=%b code=%0d, expected 0 0", halted, halt_code);
    end
    checks++;
    if (imem_req !== 1'b0 || rf_wen !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: req=%b wen=%b, expected 0 0", imem_req, rf_wen);
    end
    imem_rvalid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RV) begin
      errors++;
      $display("FAIL reset_release: req=%b addr=%h, expected 1 %h", imem_req, imem_addr, RV);
    end
    pc_m  = RV;
    ret_m = 32'd0;
  endtask

  task automatic test_zero_wait();
    fetch_retire("zero_wait", 32'h0050_0093, 0);
  endtask

  task automatic test_wait_states();
    fetch_retire("wait_states", 32'h0030_8113, 3);
  endtask

  task automatic test_rd_x0();
    fetch_retire("rd_x0", 32'h0000_0013, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[4];
    words[0] = 32'h0020_81B3;  // add x3,x1,x2
    words[1] = 32'h4020_8233;  // sub x4,x1,x2
    words[2] = 32'h0000_0033;  // add x0,x0,x0
    words[3] = 32'hFFF0_0293;  // addi x5,x0,-1
    for (int i = 0; i < 4; i++)
      fetch_retire("back_to_back", words[i], int'($urandom_range(0, 4)));
  endtask

  task automatic test_halt(input string name, input logic [31:0] word,
                           input logic [1:0] code);
    int bad;
    do_reset();
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    @(negedge clk);          // DECODE
    imem_rvalid = 1'b0;
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL %s early_halt: halted=%b in decode, expected 0", name, halted);
    end
    @(negedge clk);          // first HALT cycle
    checks++;
    if (halted !== 1'b1 || halt_code !== code) begin
      errors++;
      $display("FAIL %s halt: halted=%b code=%0d, expected 1 %0d", name, halted, halt_code, code);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      // Stray valid data while halted must be ignored.
      imem_rvalid = i[0];
      imem_rdata  = 32'h0050_0093;
      if (imem_req !== 1'b0 || rf_wen !== 1'b0 || pc !== RV || retired !== 32'd0 ||
          inst !== word || halted !== 1'b1 || halt_code !== code)
        bad++;
      @(negedge clk);
    end
    imem_rvalid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s frozen: %0d of 20 cycles not frozen (last pc=%h inst=%h req=%b)",
               name, bad, pc, inst, imem_req);
    end
  endtask

  task automatic test_timeout();
    int early;
    do_reset();
    early = 0;
    for (int i = 0; i < 16; i++) begin
      if (halted !== 1'b0 || imem_req !== 1'b1) early++;
      @(negedge clk);
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL timeout_early: %0d bad cycles before 16, expected 0", early);
    end
    checks++;
    if (halted !== 1'b1 || halt_code !== 2'd3 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_halt: halted=%b code=%0d req=%b, expected 1 3 0",
               halted, halt_code, imem_req);
    end
    do_reset();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RV || halted !== 1'b0) begin
      errors++;
      $display("FAIL timeout_restart: req=%b addr=%h halted=%b, expected 1 %h 0",
               imem_req, imem_addr, halted, RV);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    fetch_retire("mid_reset_pre", 32'h0050_0093, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0070_0193;
    @(negedge clk);          // DECODE
    imem_rvalid = 1'b0;
    @(negedge clk);          // EXEC
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || rf_wen !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_strobes: req=%b wen=%b, expected 0 0", imem_req, rf_wen);
    end
    @(negedge clk);
    checks++;
    if (pc !== RV || retired !== 32'd0 || inst !== 32'd0 || rf_wen !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: pc=%h retired=%h inst=%h wen=%b, expected %h 0 0 0",
               pc, retired, inst, rf_wen, RV);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RV) begin
      errors++;
      $display("FAIL mid_reset_refetch: req=%b addr=%h, expected 1 %h", imem_req, imem_addr, RV);
    end
    pc_m  = RV;
    ret_m = 32'd0;
  endtask

  task automatic test_retired_wrap();
    do_reset();
    force dut.retired = 32'hFFFF_FFFF;
    ret_m = 32'hFFFF_FFFF;
    fork
      begin
        repeat (2) @(negedge clk);  // released in EXEC, before the WB edge
        release dut.retired;
      end
    join_none
    fetch_retire("retired_wrap", 32'h0050_0093, 0);
  endtask

  initial begin
    rst         = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    pc_m        = RV;
    ret_m       = 32'd0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_rd_x0();
    test_back_to_back();
    test_halt("halt_ebreak", 32'h0010_0073, 2'd1);
    test_halt("halt_illegal", 32'h0000_006F, 2'd2);
    test_timeout();
    test_mid_reset();
    test_retired_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
